// File: rtl/rf_pkg.sv
// Shared constants and FSM encoding for the
// multi-port integer register file.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_NREGS  = 32;

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus of the register file:
// two read ports, two write ports, ready.
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = $clog2(RF_NREGS)
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              WE0;
    logic [ADDR_W-1:0] rd0;
    logic [DATA_W-1:0] wd0;
    logic              WE1;
    logic [ADDR_W-1:0] rd1;
    logic [DATA_W-1:0] wd1;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              ready;

    modport master (
        output rs, rt,
        output WE0, rd0, wd0,
        output WE1, rd1, wd1,
        input  A, B, ready
    );

    modport slave (
        input  rs, rt,
        input  WE0, rd0, wd0,
        input  WE1, rd1, wd1,
        output A, B, ready
    );
endinterface

// File: rtl/rf_scrub_fsm.sv
// Post-reset scrub sequencer: walks every
// entry once, then enters RUN and raises ready.
module rf_scrub_fsm
    import rf_pkg::*;
#(
    parameter int NREGS  = RF_NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              rstControl,
    output logic              ready,
    output logic              run,
    output logic              scrub_we,
    output logic [ADDR_W-1:0] scrub_addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              ready_d;

    // State, pointer and ready registers.
    always_ff @(posedge CLK) begin
        if (rstControl) begin
            state_q <= ST_SCRUB;
            ptr_q   <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready   <= ready_d;
        end
    end

    // Advance the pointer; leave SCRUB on the last entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready;
        unique case (state_q)
            ST_SCRUB: begin
                if (ptr_q == LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_SCRUB;
            end
        endcase
    end

    // A reset cycle must not touch the array.
    assign scrub_we   = (state_q == ST_SCRUB) && !rstControl;
    assign scrub_addr = ptr_q;
    assign run        = (state_q == ST_RUN);

endmodule

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with
// optional bypass, zero register and scrub.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NREGS    = RF_NREGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         CLK,
    input  logic         rstControl,
    regfile_mp_if.slave  bus
);
    localparam int ADDR_W = $clog2(NREGS);

    logic [DATA_W-1:0] mem [NREGS];
    logic              run;
    logic              scrub_we;
    logic [ADDR_W-1:0] scrub_addr;
    logic              w0_ok;
    logic              w1_ok;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;

    // Entry exists and is not the hardwired zero.
    function automatic logic live(logic [ADDR_W-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    rf_scrub_fsm #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scrub (
        .CLK        (CLK),
        .rstControl (rstControl),
        .ready      (bus.ready),
        .run        (run),
        .scrub_we   (scrub_we),
        .scrub_addr (scrub_addr)
    );

    assign w0_ok = run && !rstControl && bus.WE0 && live(bus.rd0);
    assign w1_ok = run && !rstControl && bus.WE1 && live(bus.rd1);

    // Array update; port 1 is written last so it wins.
    always_ff @(posedge CLK) begin
        if (scrub_we) begin
            mem[scrub_addr] <= '0;
        end else begin
            if (w0_ok) mem[bus.rd0] <= bus.wd0;
            if (w1_ok) mem[bus.rd1] <= bus.wd1;
        end
    end

    // Port A read value with optional forwarding.
    always_comb begin
        a_d = '0;
        if (live(bus.rs)) begin
            a_d = mem[bus.rs];
            if (BYPASS != 0) begin
                if (w0_ok && bus.rd0 == bus.rs) a_d = bus.wd0;
                if (w1_ok && bus.rd1 == bus.rs) a_d = bus.wd1;
            end
        end
    end

    // Port B read value with optional forwarding.
    always_comb begin
        b_d = '0;
        if (live(bus.rt)) begin
            b_d = mem[bus.rt];
            if (BYPASS != 0) begin
                if (w0_ok && bus.rd0 == bus.rt) b_d = bus.wd0;
                if (w1_ok && bus.rd1 == bus.rt) b_d = bus.wd1;
            end
        end
    end

    // Registered read outputs, forced to zero outside RUN.
    always_ff @(posedge CLK) begin
        if (rstControl || !run) begin
            bus.A <= '0;
            bus.B <= '0;
        end else begin
            bus.A <= a_d;
            bus.B <= b_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: default file and a
// 24-entry read-first file share one stimulus.
module tb_regfile_mp;

    logic        CLK;
    logic        rst;
    logic [4:0]  rs, rt, rd0, rd1;
    logic        we0, we1;
    logic [31:0] wd0, wd1;

    int checks   = 0;
    int failures = 0;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bi0 ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bi1 ();

    assign bi0.rs = rs;   assign bi1.rs = rs;
    assign bi0.rt = rt;   assign bi1.rt = rt;
    assign bi0.WE0 = we0; assign bi1.WE0 = we0;
    assign bi0.rd0 = rd0; assign bi1.rd0 = rd0;
    assign bi0.wd0 = wd0; assign bi1.wd0 = wd0;
    assign bi0.WE1 = we1; assign bi1.WE1 = we1;
    assign bi0.rd1 = rd1; assign bi1.rd1 = rd1;
    assign bi0.wd1 = wd1; assign bi1.wd1 = wd1;

    regfile_mp #(
        .DATA_W(32), .NREGS(32), .BYPASS(1), .ZERO_REG(1)
    ) dut0 (
        .CLK(CLK), .rstControl(rst), .bus(bi0)
    );

    regfile_mp #(
        .DATA_W(32), .NREGS(24), .BYPASS(0), .ZERO_REG(0)
    ) dut1 (
        .CLK(CLK), .rstControl(rst), .bus(bi1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: one architectural view per instance.
    int          nr[2] = '{32, 24};
    bit          zr[2] = '{1'b1, 1'b0};
    bit          bp[2] = '{1'b1, 1'b0};
    logic [31:0] mm[2][32];
    int          left[2];
    logic [31:0] eA[2];
    logic [31:0] eB[2];
    logic        erdy[2];

    function automatic bit ok(int d, logic [4:0] a);
        return (int'(a) < nr[d]) && !(zr[d] && a == 5'd0);
    endfunction

    function automatic logic [31:0] rdm(int d, logic [4:0] a);
        logic [31:0] v;
        if (!ok(d, a)) return 32'h0;
        v = mm[d][a];
        if (bp[d]) begin
            if (we0 && rd0 == a) v = wd0;
            if (we1 && rd1 == a) v = wd1;
        end
        return v;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                eA[d] = 0; eB[d] = 0; erdy[d] = 0;
                left[d] = nr[d];
            end else if (left[d] > 0) begin
                mm[d][nr[d] - left[d]] = 0;
                left[d] = left[d] - 1;
                eA[d] = 0; eB[d] = 0;
                erdy[d] = (left[d] == 0);
            end else begin
                eA[d] = rdm(d, rs);
                eB[d] = rdm(d, rt);
                if (we0 && ok(d, rd0)) mm[d][rd0] = wd0;
                if (we1 && ok(d, rd1)) mm[d][rd1] = wd1;
                erdy[d] = 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(string tag);
        model_step();
        @(posedge CLK);
        #1;
        chk({tag, ".d0.A"}, bi0.A, eA[0]);
        chk({tag, ".d0.B"}, bi0.B, eB[0]);
        chk({tag, ".d0.rdy"}, 32'(bi0.ready), 32'(erdy[0]));
        chk({tag, ".d1.A"}, bi1.A, eA[1]);
        chk({tag, ".d1.B"}, bi1.B, eB[1]);
        chk({tag, ".d1.rdy"}, 32'(bi1.ready), 32'(erdy[1]));
    endtask

    task automatic drv(logic w0, logic [4:0] a0, logic [31:0] d0,
                       logic w1, logic [4:0] a1, logic [31:0] d1,
                       logic [4:0] ra, logic [4:0] rb);
        we0 = w0; rd0 = a0; wd0 = d0;
        we1 = w1; rd1 = a1; wd1 = d1;
        rs = ra; rt = rb;
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            left[d] = 0;
            for (int i = 0; i < 32; i++) mm[d][i] = 0;
        end
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick("reset");

        // Scrub with a write attempt to entry 31 throughout.
        rst = 1'b0;
        drv(1, 31, 32'hFF, 0, 0, 0, 31, 31);
        repeat (32) tick("scrub");

        // Sweep every entry on both ports.
        for (int i = 0; i < 32; i++) begin
            drv(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            tick("sweep");
        end

        drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0); tick("w5");
        drv(0, 0, 0, 0, 0, 0, 5, 5);             tick("r5");
        drv(1, 0, 32'h1234, 0, 0, 0, 0, 0);      tick("w0");
        drv(0, 0, 0, 0, 0, 0, 0, 0);             tick("r0");

        drv(1, 7, 32'h11, 1, 7, 32'h22, 7, 7);   tick("col7");
        drv(0, 0, 0, 0, 0, 0, 7, 7);             tick("r7");

        drv(1, 0, 32'h5, 1, 25, 32'h9, 0, 0);    tick("w0_25");
        drv(0, 0, 0, 0, 0, 0, 0, 25);            tick("r0_25");

        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 1)), pick(), $urandom(),
                1'($urandom_range(0, 1)), pick(), $urandom(),
                pick(), pick());
            tick("rand");
        end

        // Restart the scrub midway through a second scrub.
        drv(1, 3, 32'hAA, 0, 0, 0, 0, 0);        tick("w3");
        drv(0, 0, 0, 0, 0, 0, 3, 3);             tick("r3");
        rst = 1'b1;                              tick("rst2");
        rst = 1'b0;
        repeat (10) tick("scrub2");
        rst = 1'b1;
        repeat (2) tick("rst3");
        rst = 1'b0;
        drv(1, 31, 32'hFF, 1, 3, 32'h77, 3, 31);
        repeat (32) tick("scrub3");
        drv(0, 0, 0, 0, 0, 0, 3, 31);            tick("r3_31");

        for (int i = 0; i < 100; i++) begin
            drv(1'($urandom_range(0, 1)), pick(), $urandom(),
                1'($urandom_range(0, 1)), pick(), $urandom(),
                pick(), pick());
            tick("rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
